// File: rtl/rob_retire_buffer_if.sv
// Dispatch, completion-update and retire signals of the reorder buffer.
// The master side issues dispatch/update requests; the slave side is the reorder buffer itself.
interface rob_retire_buffer_if #(
  parameter int N      = 2,
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 6,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [N-1:0]        disp_valid;
  logic [N*TAG_W-1:0]  disp_dest_pr;
  logic [N*TAG_W-1:0]  disp_old_pr;
  logic [N*ADDR_W-1:0] disp_pc;
  logic [N-1:0]        disp_is_branch;
  logic [N-1:0]        disp_pred_taken;
  logic [N*ADDR_W-1:0] disp_pred_target;
  logic [N*IDX_W-1:0]  disp_idx;
  logic [IDX_W:0]      free_slots;

  logic [N-1:0]        upd_valid;
  logic [N*IDX_W-1:0]  upd_idx;
  logic [N-1:0]        upd_branch_taken;
  logic [N*ADDR_W-1:0] upd_branch_target;

  logic [N-1:0]        retire_valid;
  logic [N*TAG_W-1:0]  retire_dest_pr;
  logic [N*TAG_W-1:0]  retire_old_pr;
  logic                mispredict;
  logic [ADDR_W-1:0]   mispredict_target;

  modport master (
    output disp_valid, disp_dest_pr, disp_old_pr, disp_pc, disp_is_branch,
           disp_pred_taken, disp_pred_target,
           upd_valid, upd_idx, upd_branch_taken, upd_branch_target,
    input  disp_idx, free_slots, retire_valid, retire_dest_pr, retire_old_pr,
           mispredict, mispredict_target
  );

  modport slave (
    input  disp_valid, disp_dest_pr, disp_old_pr, disp_pc, disp_is_branch,
           disp_pred_taken, disp_pred_target,
           upd_valid, upd_idx, upd_branch_taken, upd_branch_target,
    output disp_idx, free_slots, retire_valid, retire_dest_pr, retire_old_pr,
           mispredict, mispredict_target
  );
endinterface

// File: rtl/rob_retire_buffer.sv
// Reorder buffer: in-order allocate, out-of-order complete, up to N in-order retires per cycle.
// Define ROB_FULL_STALL_CNT_EN to add the saturating full_stall_cnt output.
module rob_retire_buffer #(
  parameter int N      = 2,
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 6,
  parameter int ADDR_W = 32
) (
  input  logic clock,
  input  logic reset,
  rob_retire_buffer_if.slave bus
`ifdef ROB_FULL_STALL_CNT_EN
  ,
  output logic [31:0] full_stall_cnt
`endif
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DEPTH-1:0]  valid_q, complete_q;
  logic [DEPTH-1:0]  is_br_q, pred_taken_q, taken_q;
  logic [TAG_W-1:0]  dest_q     [DEPTH];
  logic [TAG_W-1:0]  old_q      [DEPTH];
  logic [ADDR_W-1:0] pc_q       [DEPTH];
  logic [ADDR_W-1:0] pred_tgt_q [DEPTH];
  logic [ADDR_W-1:0] tgt_q      [DEPTH];

  idx_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d, free_q, free_d;

  logic [N-1:0]      accept, ret;
  cnt_t              nacc, nret;
  logic              mp, chain, mis;
  idx_t              ri;
  logic [ADDR_W-1:0] mp_target;

  logic [N-1:0]       retire_valid_q;
  logic [N*TAG_W-1:0] retire_dest_q, retire_old_q;
  logic               mispredict_q;
  logic [ADDR_W-1:0]  mispredict_target_q;

  always_comb begin
    bus.disp_idx = '0;
    for (int i = 0; i < N; i++) begin
      bus.disp_idx[i*IDX_W +: IDX_W] = tail_q + idx_t'(i);
    end
  end

  // Retire scan stops at the first incomplete entry or right after a mispredicting branch.
  always_comb begin
    accept    = '0;
    nacc      = '0;
    ret       = '0;
    nret      = '0;
    mp        = 1'b0;
    mp_target = '0;
    chain     = 1'b1;
    mis       = 1'b0;
    ri        = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.disp_valid[i] && (cnt_t'(i) < free_q)) begin
        accept[i] = 1'b1;
        nacc      = nacc + cnt_t'(1);
      end
    end
    for (int k = 0; k < N; k++) begin
      ri = head_q + idx_t'(k);
      if (chain && valid_q[ri] && complete_q[ri]) begin
        ret[k] = 1'b1;
        nret   = nret + cnt_t'(1);
        mis    = is_br_q[ri] && ((taken_q[ri] != pred_taken_q[ri]) ||
                                 (taken_q[ri] && (tgt_q[ri] != pred_tgt_q[ri])));
        if (mis) begin
          mp        = 1'b1;
          mp_target = taken_q[ri] ? tgt_q[ri] : pc_q[ri] + ADDR_W'(4);
          chain     = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_comb begin
    if (mp) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + idx_t'(nret);
      tail_d  = tail_q + idx_t'(nacc);
      count_d = count_q + nacc - nret;
    end
    free_d = cnt_t'(DEPTH) - count_d;
  end

  // Order matters: retired entries clear first, then updates, then new allocations.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q             <= '0;
      complete_q          <= '0;
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      free_q              <= cnt_t'(DEPTH);
      retire_valid_q      <= '0;
      retire_dest_q       <= '0;
      retire_old_q        <= '0;
      mispredict_q        <= 1'b0;
      mispredict_target_q <= '0;
    end else begin
      head_q              <= head_d;
      tail_q              <= tail_d;
      count_q             <= count_d;
      free_q              <= free_d;
      retire_valid_q      <= ret;
      mispredict_q        <= mp;
      mispredict_target_q <= mp_target;
      for (int k = 0; k < N; k++) begin
        retire_dest_q[k*TAG_W +: TAG_W] <= ret[k] ? dest_q[head_q + idx_t'(k)] : '0;
        retire_old_q[k*TAG_W +: TAG_W]  <= ret[k] ? old_q[head_q + idx_t'(k)] : '0;
      end
      if (mp) begin
        valid_q    <= '0;
        complete_q <= '0;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (ret[k]) valid_q[head_q + idx_t'(k)] <= 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (bus.upd_valid[i] && valid_q[bus.upd_idx[i*IDX_W +: IDX_W]]) begin
            complete_q[bus.upd_idx[i*IDX_W +: IDX_W]] <= 1'b1;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (accept[i]) begin
            valid_q[tail_q + idx_t'(i)]    <= 1'b1;
            complete_q[tail_q + idx_t'(i)] <= 1'b0;
          end
        end
      end
    end
  end

  // Payload storage needs no reset: it is only consumed behind valid/complete.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (accept[i] && !mp) begin
        dest_q[tail_q + idx_t'(i)]       <= bus.disp_dest_pr[i*TAG_W +: TAG_W];
        old_q[tail_q + idx_t'(i)]        <= bus.disp_old_pr[i*TAG_W +: TAG_W];
        pc_q[tail_q + idx_t'(i)]         <= bus.disp_pc[i*ADDR_W +: ADDR_W];
        is_br_q[tail_q + idx_t'(i)]      <= bus.disp_is_branch[i];
        pred_taken_q[tail_q + idx_t'(i)] <= bus.disp_pred_taken[i];
        pred_tgt_q[tail_q + idx_t'(i)]   <= bus.disp_pred_target[i*ADDR_W +: ADDR_W];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bus.upd_valid[i] && valid_q[bus.upd_idx[i*IDX_W +: IDX_W]] && !mp) begin
        taken_q[bus.upd_idx[i*IDX_W +: IDX_W]] <= bus.upd_branch_taken[i];
        tgt_q[bus.upd_idx[i*IDX_W +: IDX_W]]   <= bus.upd_branch_target[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign bus.free_slots        = free_q;
  assign bus.retire_valid      = retire_valid_q;
  assign bus.retire_dest_pr    = retire_dest_q;
  assign bus.retire_old_pr     = retire_old_q;
  assign bus.mispredict        = mispredict_q;
  assign bus.mispredict_target = mispredict_target_q;

`ifdef ROB_FULL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating; survives mispredict flushes so it measures total full-ROB pressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if ((free_q == '0) && (|bus.disp_valid) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign full_stall_cnt = stall_cnt_q;
`endif
endmodule
